// File: rtl/nano_dsi_pkg.sv
// Shared D-PHY clock-lane definitions: LP line levels and the receiver FSM
// state numbering (kept aligned with the transmitter where names match).
package nano_dsi_pkg;

    // LP levels as {p, n}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [1:0] LP10 = 2'b10;

    // Width and ceiling of the state-duration counter
    localparam int         CNT_W   = 8;
    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_LP11     = 3'd0,
        ST_LP01     = 3'd1,
        ST_LP00     = 3'd2,
        ST_HS_CLK   = 3'd3,
        ST_HS_TRAIL = 3'd4
    } rx_state_t;

endpackage

// File: rtl/nano_dsi_lp_sync.sv
// Synchroniser for the LP pair, plus an optional deglitch filter on the copy
// that feeds the FSM. Build macro: NANO_DSI_CLK_RX_DEGLITCH_EN (when defined,
// the FSM copy only follows a level held for 3 consecutive cycles).
module nano_dsi_lp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] lp_in,
    output logic [1:0] lp_sync,
    output logic [1:0] lp_filt
);
    import nano_dsi_pkg::*;

    logic [1:0] sync_p [SYNC_STAGES];

    // Shift the asynchronous pins through the synchroniser; idle level is LP11
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= LP11;
        end else begin
            sync_p[0] <= lp_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
        end
    end

    assign lp_sync = sync_p[SYNC_STAGES-1];

`ifdef NANO_DSI_CLK_RX_DEGLITCH_EN
    logic [1:0] lp_p1;
    logic [1:0] lp_p2;
    logic [1:0] filt_q;
    logic       stable;

    // Level is accepted once the current and two previous samples agree
    assign stable  = (lp_sync == lp_p1) && (lp_p1 == lp_p2);
    assign lp_filt = stable ? lp_sync : filt_q;

    // History of synchronised samples and the last accepted level
    always_ff @(posedge clk) begin
        if (rst) begin
            lp_p1  <= LP11;
            lp_p2  <= LP11;
            filt_q <= LP11;
        end else begin
            lp_p1 <= lp_sync;
            lp_p2 <= lp_p1;
            if (stable) filt_q <= lp_sync;
        end
    end
`else
    assign lp_filt = lp_sync;
`endif

endmodule

// File: rtl/nano_dsi_clk_rx.sv
// D-PHY clock-lane receive monitor: follows LP11->LP01->LP00->HS->trail->LP11,
// checks minimum LP durations and flags sequence/timing errors.
// Build macro: NANO_DSI_CLK_RX_DEGLITCH_EN enables the LP deglitch filter.
module nano_dsi_clk_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lp_p,
    input  logic       lp_n,
    input  logic       hs_in,
    input  logic [7:0] cfg_lpx,
    input  logic [7:0] cfg_hs_prep,
    input  logic [7:0] cfg_hs_trail,
    output logic       hs_active,
    output logic       hs_edge,
    output logic [1:0] lp_state,
    output logic       err_seq,
    output logic       err_timing
);
    import nano_dsi_pkg::*;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [1:0]       lp_fsm;
    logic [1:0]       lp_last;
    logic             hs_prev;
    logic             hs_tgl;
    rx_state_t        state_q;
    rx_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_seq_d;
    logic             err_tim_d;

    nano_dsi_lp_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lp_sync (
        .clk     (clk),
        .rst     (rst),
        .lp_in   ({lp_p, lp_n}),
        .lp_sync (lp_state),
        .lp_filt (lp_fsm)
    );

    // HS toggle detect: hs_in is already in the clk domain
    always_ff @(posedge clk) begin
        hs_prev <= hs_in;
    end

    assign hs_tgl = hs_in ^ hs_prev;

    // Next-state and error decode; LP11 checks take precedence over HS edges
    always_comb begin
        state_d   = state_q;
        err_seq_d = 1'b0;
        err_tim_d = 1'b0;
        unique case (state_q)
            ST_LP11: begin
                if (lp_fsm == LP01) begin
                    state_d = ST_LP01;
                end else if (lp_fsm != LP11 && lp_fsm != lp_last) begin
                    // flag entry into an illegal level once, not every cycle it is held
                    err_seq_d = 1'b1;
                end
            end
            ST_LP01: begin
                if (lp_fsm == LP00) begin
                    state_d   = ST_LP00;
                    err_tim_d = (cnt_q < cfg_lpx);
                end else if (lp_fsm == LP11) begin
                    state_d = ST_LP11;
                end else if (lp_fsm == LP10) begin
                    state_d   = ST_LP11;
                    err_seq_d = 1'b1;
                end
            end
            ST_LP00: begin
                if (lp_fsm == LP11) begin
                    state_d   = ST_LP11;
                    err_seq_d = 1'b1;
                end else if (hs_tgl) begin
                    state_d   = ST_HS_CLK;
                    err_tim_d = (cnt_q < cfg_hs_prep);
                end
            end
            ST_HS_CLK: begin
                if (lp_fsm == LP11) begin
                    state_d   = ST_LP11;
                    err_seq_d = 1'b1;
                end else if (!hs_tgl && cnt_q >= cfg_hs_trail) begin
                    state_d = ST_HS_TRAIL;
                end
            end
            ST_HS_TRAIL: begin
                if (lp_fsm == LP11) begin
                    state_d = ST_LP11;
                end else if (hs_tgl) begin
                    state_d = ST_HS_CLK;
                end
            end
            default: state_d = ST_LP11;
        endcase
    end

    // Duration counter: restarts on every state change and, in HS, on every edge
    always_comb begin
        cnt_d = sat_inc(cnt_q);
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_HS_CLK && hs_tgl) begin
            cnt_d = '0;
        end
    end

    // State, counter and previous LP level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LP11;
            cnt_q   <= '0;
            lp_last <= LP11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lp_last <= lp_fsm;
        end
    end

    // Registered status; the HS edge that opens a burst is reported as well
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_active  <= 1'b0;
            hs_edge    <= 1'b0;
            err_seq    <= 1'b0;
            err_timing <= 1'b0;
        end else begin
            hs_active  <= (state_d == ST_HS_CLK);
            hs_edge    <= hs_tgl && (state_d == ST_HS_CLK);
            err_seq    <= err_seq_d;
            err_timing <= err_tim_d && !err_seq_d;
        end
    end

endmodule

// File: doc/nano_dsi_clk_rx.md
Name: nano_dsi_clk_rx

Overview:
Receive-side monitor for a D-PHY clock lane on the nano-PMOD, used for loopback test and bring-up of the clock-lane transmitter.
- Synchronises the two LP single-ended inputs into clk.
- Tracks the LP11 -> LP01 -> LP00 -> HS-zero -> HS-clock -> trail -> LP11 sequence.
- Checks minimum LP timing against config registers.
- Reports HS-active status, HS clock edges and protocol/timing errors to the debug/status logic.

Parameters:
SYNC_STAGES, 2, number of flip-flop synchroniser stages on lp_p/lp_n (minimum 2).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
lp_p  in  1  LP receiver, P line (asynchronous)
lp_n  in  1  LP receiver, N line (asynchronous)
hs_in  in  1  HS differential receiver output, already registered in clk domain by IOB
cfg_lpx  in  8  minimum LP01 duration, clk cycles
cfg_hs_prep  in  8  minimum LP00 duration before first HS edge, clk cycles
cfg_hs_trail  in  8  HS idle cycles (no hs_in edge) that define end of burst
hs_active  out  1  high while lane is in HS clock state
hs_edge  out  1  one-cycle pulse per hs_in transition while in HS clock state
lp_state  out  2  synchronised {p,n} LP level
err_seq  out  1  one-cycle pulse on illegal LP transition
err_timing  out  1  one-cycle pulse on LP duration violation

Behaviour:
Interface:
- Reset rst, synchronous, active-high; clock clk.
- All outputs are 0 after reset, except lp_state = 2'b11 (synchroniser chains reset to 1).

Input conditioning:
- lp_p/lp_n pass through SYNC_STAGES flops; the result is lp_state.
- hs_prev registers hs_in; edge = hs_in ^ hs_prev.

Duration counter:
- 8-bit, cleared to 0 on every FSM state change, else increments, saturating at 255.

FSM states and transitions:
- ST_LP11:
  - lp_state 01 -> ST_LP01.
  - 00 or 10 -> err_seq, stay.
- ST_LP01:
  - 00: if cnt < cfg_lpx, pulse err_timing; -> ST_LP00.
  - 11 -> ST_LP11, no error (aborted request).
  - 10 -> err_seq, -> ST_LP11.
- ST_LP00 (HS-prepare / HS-zero, hs_in expected 0):
  - First edge: if cnt < cfg_hs_prep, pulse err_timing; -> ST_HS_CLK.
  - 11 -> err_seq, -> ST_LP11.
- ST_HS_CLK:
  - hs_active=1; hs_edge = edge.
  - Idle counter (the duration counter, cleared on each edge) reaching cfg_hs_trail -> ST_HS_TRAIL.
  - lp_state 11 before that -> err_seq, -> ST_LP11.
- ST_HS_TRAIL:
  - hs_active=0.
  - lp_state 11 -> ST_LP11.
  - An edge -> back to ST_HS_CLK, no error (trail too short on transmitter side is tolerated).

Output latency:
- hs_active, hs_edge, err_* are registered: one cycle after the state/condition.
- FSM reacts one cycle after lp_state changes; lp_state itself lags the pin by SYNC_STAGES cycles.

Boundary and simultaneous-event rules:
- cfg_* = 0: comparisons always pass.
- Saturated counter (255) compares as 255.
- Simultaneous edge and lp_state==11 in ST_LP00: the LP11 rule wins (err_seq, -> ST_LP11).
- err_seq and err_timing never pulse in the same cycle; err_seq has priority.
- rst mid-burst: immediately ST_LP11, outputs cleared, no error pulse.

Optional Feature:
NANO_DSI_CLK_RX_DEGLITCH_EN:
- Defined: the FSM sees a filtered LP state, updated only when the synchronised lp_state has been identical for 3 consecutive cycles. This adds 2 cycles of latency, and single/double-cycle LP glitches are ignored. lp_state output remains unfiltered.
- Undefined: the FSM uses the synchronised lp_state directly.

Decomposition:
- Shared package nano_dsi_pkg holds:
  - LP level constants LP11/LP01/LP00/LP10.
  - The receiver FSM state encoding (3 bits, shared with the transmitter's state numbering where names match).
- One sub-module, nano_dsi_lp_sync: SYNC_STAGES synchroniser plus optional deglitch filter, instantiated once for the 2-bit LP pair.

Test Plan:
1. Nominal: cfg_lpx=4, cfg_hs_prep=3, cfg_hs_trail=6. Stimulus: LP11, LP01 for 6 cycles, LP00 for 5, then hs_in toggling every cycle for 20 cycles, idle 8, LP11. Required: hs_active high ~20 cycles, 20 hs_edge pulses, zero err pulses, final state ST_LP11.
2. Short LP01: LP01 held 2 cycles with cfg_lpx=4 -> exactly one err_timing pulse on entry to LP00; sequence still completes.
3. Illegal LP10 while in ST_LP11 -> one err_seq pulse, state unchanged, hs_active stays 0.
4. Abrupt exit: LP11 driven while toggling in ST_HS_CLK -> err_seq pulse, hs_active falls within 1 cycle of FSM reaction.
5. Reset during ST_HS_CLK -> next cycle all outputs 0, lp_state 11, no err pulse.
6. With NANO_DSI_CLK_RX_DEGLITCH_EN: a 2-cycle LP01 glitch in ST_LP11 causes no transition; without the macro it enters ST_LP01 then returns to ST_LP11 with no error.
